// File: rtl/digitron_driver.sv
// rtl/digitron_driver.sv - 6-digit multiplexed seven-segment driver with iterative BCD conversion
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module digitron_driver #(
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_DIV      = 12500000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] number_to_show,
  input  logic [5:0]  point_position,
  input  logic [5:0]  shank_position,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [5:0]  dig_sel,
  output logic        conv_busy
);

  localparam int SCAN_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t       state_q, state_d;
  logic [19:0]  last_val;
  logic [43:0]  shift_reg;
  logic [43:0]  shift_adj;
  logic [4:0]   bit_cnt;
  logic [23:0]  disp_bcd;
  logic [19:0]  sat_val;

  logic [SCAN_W-1:0]  scan_cnt;
  logic [2:0]         scan_idx;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_phase;

  logic [3:0]  cur_digit;
  logic [6:0]  seg_code;
  logic [6:0]  seg_lit;
  logic [5:0]  blank_vec;
  logic        hide;

  assign conv_busy = (state_q == SHIFT);
  assign sat_val   = (number_to_show > 20'd999999) ? 20'd999999 : number_to_show;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (number_to_show != last_val) state_d = SHIFT;
      SHIFT:   if (bit_cnt == 5'd19) state_d = LOAD;
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Double-dabble: correct every BCD nibble >= 5 before each left shift.
  always_comb begin
    shift_adj = shift_reg;
    for (int k = 0; k < 6; k++) begin
      if (shift_reg[20+4*k +: 4] >= 4'd5)
        shift_adj[20+4*k +: 4] = shift_reg[20+4*k +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_val  <= '0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      disp_bcd  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (number_to_show != last_val) begin
            last_val  <= number_to_show;
            shift_reg <= {24'd0, sat_val};
            bit_cnt   <= '0;
          end
        end
        SHIFT: begin
          shift_reg <= {shift_adj[42:0], 1'b0};
          bit_cnt   <= bit_cnt + 5'd1;
        end
        LOAD:    disp_bcd <= shift_reg[43:20];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == 3'd5) ? 3'd0 : scan_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  always_comb begin
    case (scan_idx)
      3'd0:    cur_digit = disp_bcd[23:20];
      3'd1:    cur_digit = disp_bcd[19:16];
      3'd2:    cur_digit = disp_bcd[15:12];
      3'd3:    cur_digit = disp_bcd[11:8];
      3'd4:    cur_digit = disp_bcd[7:4];
      3'd5:    cur_digit = disp_bcd[3:0];
      default: cur_digit = 4'hF;
    endcase
  end

  always_comb begin
    case (cur_digit)
      4'd0:    seg_code = 7'h3F;
      4'd1:    seg_code = 7'h06;
      4'd2:    seg_code = 7'h5B;
      4'd3:    seg_code = 7'h4F;
      4'd4:    seg_code = 7'h66;
      4'd5:    seg_code = 7'h6D;
      4'd6:    seg_code = 7'h7D;
      4'd7:    seg_code = 7'h07;
      4'd8:    seg_code = 7'h7F;
      4'd9:    seg_code = 7'h6F;
      default: seg_code = 7'h00;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic blank_run;
  // Blanking chain stops at a nonzero digit or a lit point; digit 5 is never blanked.
  always_comb begin
    blank_vec = '0;
    blank_run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      blank_run    = blank_run & (disp_bcd[23-4*i -: 4] == 4'd0) & ~point_position[i];
      blank_vec[i] = blank_run;
    end
  end
`else
  assign blank_vec = '0;
`endif

  assign hide    = blank_vec[scan_idx] | (shank_position[scan_idx] & blink_phase);
  assign seg_lit = hide ? 7'h00 : seg_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg     <= SEG_OFF;
      dp      <= DP_OFF;
      dig_sel <= 6'b111111;
    end else begin
      seg     <= SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
      dp      <= SEG_ACTIVE_LOW ? ~point_position[scan_idx] : point_position[scan_idx];
      dig_sel <= ~(6'b000001 << scan_idx);
    end
  end

endmodule
